// File: rtl/store_align_unit_pkg.sv
// Shared types and helpers for the store alignment path: access sizes,
// FSM states and the size-to-mask / size-to-byte-count decoders.
package store_align_unit_pkg;

  // Store access size as encoded by the MEM-stage control
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Store sequencing states: waiting for a request, first word beat, second word beat
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10
  } state_e;

  localparam int LANE_COUNT = 4;
  localparam int LANE_BITS  = 8;

  // Byte-lane mask of an unshifted access of the given size
  function automatic logic [3:0] size_mask(input size_e size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Number of bytes written by an access of the given size (0 for reserved)
  function automatic logic [2:0] size_bytes(input size_e size);
    logic [2:0] count;
    case (size)
      SZ_BYTE: count = 3'd1;
      SZ_HALF: count = 3'd2;
      SZ_WORD: count = 3'd4;
      default: count = 3'd0;
    endcase
    return count;
  endfunction

  // True when an access starting at this lane offset runs past the word boundary
  function automatic logic crosses_word(input logic [1:0] offset, input size_e size);
    logic [3:0] end_lane;
    end_lane = {2'b00, offset} + {1'b0, size_bytes(size)};
    return (end_lane > 4'd4);
  endfunction

endpackage

// File: rtl/store_align_unit_lane_shifter.sv
// Combinational lane placement for one store beat. The narrowed data and its
// mask are shifted up by the byte offset into a two-word window; the first beat
// takes the low word of that window and the second beat takes the high word,
// so bytes that spill past the boundary land at the bottom of the next word.
module store_align_unit_lane_shifter
  import store_align_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  input  logic [1:0]  offset,
  input  logic        beat2,
  output logic [31:0] wdata,
  output logic [3:0]  be
);

  logic [31:0] narrow_data;
  logic [63:0] spread_data;
  logic [7:0]  spread_mask;

  // Zero every byte the access size does not cover so unused lanes drive 0
  always_comb begin
    narrow_data = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      narrow_data[LANE_BITS*i +: LANE_BITS] = mask[i] ? data[LANE_BITS*i +: LANE_BITS] : 8'h00;
    end
  end

  // Place data and enables at the byte offset and pick the word for this beat
  always_comb begin
    spread_data = {32'h0000_0000, narrow_data} << {offset, 3'b000};
    spread_mask = {4'b0000, mask} << offset;
    if (beat2) begin
      wdata = spread_data[63:32];
      be    = spread_mask[7:4];
    end else begin
      wdata = spread_data[31:0];
      be    = spread_mask[3:0];
    end
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a register-width store from the MEM stage,
// places it on the little-endian byte lanes of the data-memory word and issues
// one or two write beats over a valid/ready handshake. Misaligned accesses that
// cross a word boundary are split into two beats when SPLIT_EN is set and are
// rejected with an err pulse otherwise. Every output comes from a flop.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_size,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] WORD_STEP = AW'(4);

  state_e      state;

  logic [31:0] cap_data;
  logic [3:0]  cap_mask;
  logic [1:0]  cap_off;
  logic        cap_split;

  size_e       req_size_e;
  logic [1:0]  req_off;
  logic        req_rsvd;
  logic        req_cross;
  logic        req_reject;

  logic [31:0] sh_data;
  logic [3:0]  sh_mask;
  logic [1:0]  sh_off;
  logic        sh_beat2;
  logic [31:0] sh_wdata;
  logic [3:0]  sh_be;

  assign req_size_e = size_e'(req_size);
  assign req_off    = req_addr[1:0];
  assign req_rsvd   = (req_size_e == SZ_RSVD);
  assign req_cross  = crosses_word(req_off, req_size_e);
  assign req_reject = req_rsvd || (req_cross && !SPLIT_EN);

  // Feed the shared shifter with the incoming request while idle (first beat is
  // registered on acceptance) and with the captured request afterwards (second beat)
  always_comb begin
    sh_data  = cap_data;
    sh_mask  = cap_mask;
    sh_off   = cap_off;
    sh_beat2 = 1'b1;
    if (state == ST_IDLE) begin
      sh_data  = req_data;
      sh_mask  = size_mask(req_size_e);
      sh_off   = req_off;
      sh_beat2 = 1'b0;
    end
  end

  store_align_unit_lane_shifter u_lane_shifter (
    .data   (sh_data),
    .mask   (sh_mask),
    .offset (sh_off),
    .beat2  (sh_beat2),
    .wdata  (sh_wdata),
    .be     (sh_be)
  );

  // Store sequencer: accepts a request, presents each beat until memory takes
  // it, and pulses done or err for exactly one cycle on the way back to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cap_data  <= '0;
      cap_mask  <= '0;
      cap_off   <= '0;
      cap_split <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_reject) begin
              err <= 1'b1;
            end else begin
              cap_data  <= req_data;
              cap_mask  <= size_mask(req_size_e);
              cap_off   <= req_off;
              cap_split <= req_cross;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[AW-1:2], 2'b00};
              mem_wdata <= sh_wdata;
              mem_be    <= sh_be;
              req_ready <= 1'b0;
              state     <= ST_BEAT1;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            if (cap_split) begin
              mem_addr  <= mem_addr + WORD_STEP;
              mem_wdata <= sh_wdata;
              mem_be    <= sh_be;
              state     <= ST_BEAT2;
            end else begin
              mem_valid <= 1'b0;
              done      <= 1'b1;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        ST_BEAT2: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
